voice_allocator: RTL and testbench

- Polyphony scheduler for the synth.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note to one of NUM_VOICES voice slots.
- Each slot drives one frequency-lookup/square-wave datapath instance.
- Issues a one-hot load strobe and a shared note/octave bus; tracks slot occupancy and age; steals or rejects when all slots are busy.

---
 rtl/voice_allocator.sv | 103 ++++++++++
 tb/tb_voice_allocator.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphony scheduler assigning note events to NUM_VOICES voice slots.
// Ports: clk; reset (async, active-low); ev_valid/ev_ready/ev_on/ev_note/ev_octave event handshake;
//   voice_ld one-hot load strobe with voice_note/voice_octave bus; voice_active slot play enables;
//   drop pulses when a note-on is rejected.
// Config: define VOICE_ALLOC_STEAL_EN to steal the oldest slot when all slots are busy.
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ev_valid,
  output logic                  ev_ready,
  input  logic                  ev_on,
  input  logic [3:0]            ev_note,
  input  logic [2:0]            ev_octave,
  output logic [NUM_VOICES-1:0] voice_ld,
  output logic [3:0]            voice_note,
  output logic [2:0]            voice_octave,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  drop
);
  localparam int IW = $clog2(NUM_VOICES);
  localparam logic [IW-1:0] LAST = IW'(NUM_VOICES - 1);
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
  state_t state, state_n;
  logic c_on;
  logic [3:0] c_note;
  logic [2:0] c_oct;
  logic [IW-1:0] idx, m_idx, f_idx, o_idx, m_idx_n, f_idx_n, o_idx_n, tgt;
  logic m_ok, f_ok, o_ok, m_ok_n, f_ok_n, o_ok_n, hit, older, bad, full_drop, drop_n;
  logic [AGE_W-1:0] o_age, o_age_n;
  logic [3:0] s_note [NUM_VOICES];
  logic [2:0] s_oct [NUM_VOICES];
  logic [AGE_W-1:0] s_age [NUM_VOICES];
  logic [NUM_VOICES-1:0] clr, ld_n, clr_n;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && ev_valid) state_n = SCAN;
    if (state == SCAN && idx == LAST) state_n = COMMIT;
    if (state == COMMIT) state_n = IDLE;
  end
  always_comb ev_ready = reset && state == IDLE;
  // Running scan results including the slot examined this cycle; on the last
  // slot these fold directly into the registered commit decision.
  always_comb begin
    hit = voice_active[idx] && s_note[idx] == c_note && s_oct[idx] == c_oct;
    m_ok_n = m_ok | hit;
    m_idx_n = m_ok ? m_idx : idx;
    f_ok_n = f_ok | !voice_active[idx];
    f_idx_n = f_ok ? f_idx : idx;
    older = voice_active[idx] && (!o_ok || s_age[idx] > o_age);
    o_ok_n = o_ok | voice_active[idx];
    o_idx_n = older ? idx : o_idx;
    o_age_n = older ? s_age[idx] : o_age;
    tgt = m_ok_n ? m_idx_n : f_ok_n ? f_idx_n : o_idx_n;
    bad = c_note >= 4'd12;
`ifdef VOICE_ALLOC_STEAL_EN
    full_drop = 1'b0;
`else
    full_drop = !m_ok_n && !f_ok_n;
`endif
    ld_n = (c_on && !bad && !full_drop) ? NUM_VOICES'(1) << tgt : '0;
    drop_n = c_on && (bad || full_drop);
    clr_n = (!c_on && m_ok_n) ? NUM_VOICES'(1) << m_idx_n : '0;
  end
  // Slot state is updated at the end of COMMIT from the registered strobes.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      {c_on, c_note, c_oct, idx, m_idx, f_idx, o_idx, m_ok, f_ok, o_ok, o_age} <= '0;
      {voice_ld, drop, voice_note, voice_octave, voice_active, clr} <= '0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        s_note[k] <= '0;
        s_oct[k] <= '0;
        s_age[k] <= '0;
      end
    end else begin
      if (state == IDLE && ev_valid) begin
        {c_on, c_note, c_oct} <= {ev_on, ev_note, ev_octave};
        {idx, m_ok, f_ok, o_ok} <= '0;
      end
      if (state == SCAN) begin
        idx <= idx + IW'(1);
        {m_ok, m_idx, f_ok, f_idx, o_ok, o_idx, o_age} <= {m_ok_n, m_idx_n, f_ok_n, f_idx_n, o_ok_n, o_idx_n, o_age_n};
      end
      voice_ld <= (state == SCAN && idx == LAST) ? ld_n : '0;
      drop <= state == SCAN && idx == LAST && drop_n;
      clr <= (state == SCAN && idx == LAST) ? clr_n : '0;
      if (state == SCAN && idx == LAST && |ld_n) {voice_note, voice_octave} <= {c_note, c_oct};
      if (state == COMMIT)
        for (int k = 0; k < NUM_VOICES; k++)
          if (voice_ld[k]) begin
            s_note[k] <= voice_note;
            s_oct[k] <= voice_octave;
            s_age[k] <= '0;
            voice_active[k] <= 1'b1;
          end else if (clr[k]) voice_active[k] <= 1'b0;
          else if (voice_active[k] && |voice_ld && !(&s_age[k])) s_age[k] <= s_age[k] + AGE_W'(1);
    end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: randomized and directed checks of voice_allocator against a slot-level model.
module tb_voice_allocator;
  localparam int NV = 4;
  logic clk = 1'b0, reset = 1'b1, ev_valid = 1'b0, ev_on = 1'b0, ev_ready, drop;
  logic [3:0] ev_note = '0, voice_note;
  logic [2:0] ev_octave = '0, voice_octave;
  logic [NV-1:0] voice_ld, voice_active;
  int tests = 0, fails = 0;
  logic [NV-1:0] got_ld;
  logic got_drop;
  logic [3:0] got_note;
  logic [2:0] got_oct;
  voice_allocator #(.NUM_VOICES(NV), .AGE_W(4)) dut (
    .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on),
    .ev_note(ev_note), .ev_octave(ev_octave), .voice_ld(voice_ld), .voice_note(voice_note),
    .voice_octave(voice_octave), .voice_active(voice_active), .drop(drop)
  );
  initial forever #5 clk = ~clk;
  initial #1 reset = 1'b0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask
  logic m_act [NV];
  logic [3:0] m_note [NV];
  logic [2:0] m_oct [NV];
  int m_age [NV];
  int k = -1, p_t, p_clr;
  logic [NV-1:0] p_ld;
  logic p_drop;
  logic [3:0] p_n;
  logic [2:0] p_o;
  function automatic logic [NV-1:0] act_vec();
    logic [NV-1:0] v;
    for (int i = 0; i < NV; i++) v[i] = m_act[i];
    return v;
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_ready", ev_ready, 0);
      chk("rst_active", voice_active, 0);
      chk("rst_ld", voice_ld, 0);
      chk("rst_drop", drop, 0);
      chk("rst_bus", {voice_note, voice_octave}, 0);
      for (int i = 0; i < NV; i++) begin
        m_act[i] = 0; m_note[i] = 0; m_oct[i] = 0; m_age[i] = 0;
      end
      k = -1;
    end else begin
      chk("ready", ev_ready, k < 0);
      chk("active", voice_active, act_vec());
      chk("ld", voice_ld, k == NV + 1 ? p_ld : 0);
      chk("drop", drop, k == NV + 1 && p_drop);
      if (k == NV + 1 && p_ld != 0) begin
        chk("note", voice_note, p_n);
        chk("octave", voice_octave, p_o);
      end
      if (k == NV + 1) begin
        if (p_ld != 0) begin
          for (int i = 0; i < NV; i++)
            if (m_act[i] && i != p_t) m_age[i] = m_age[i] < 15 ? m_age[i] + 1 : 15;
          m_act[p_t] = 1; m_note[p_t] = p_n; m_oct[p_t] = p_o; m_age[p_t] = 0;
        end
        if (p_clr >= 0) m_act[p_clr] = 0;
        k = -1;
      end else if (k >= 0) k++;
      else if (ev_valid) begin
        int m, f, o;
        m = -1; f = -1; o = -1;
        for (int i = 0; i < NV; i++) begin
          if (m_act[i] && m_note[i] == ev_note && m_oct[i] == ev_octave && m < 0) m = i;
          if (!m_act[i] && f < 0) f = i;
          if (m_act[i] && (o < 0 || m_age[i] > m_age[o])) o = i;
        end
        p_ld = 0; p_drop = 0; p_clr = -1; p_t = -1; p_n = ev_note; p_o = ev_octave;
        if (ev_on) begin
          if (ev_note >= 12) p_drop = 1;
          else begin
`ifdef VOICE_ALLOC_STEAL_EN
            p_t = m >= 0 ? m : f >= 0 ? f : o;
`else
            p_t = m >= 0 ? m : f >= 0 ? f : -1;
`endif
            if (p_t < 0) p_drop = 1;
            else p_ld = NV'(1) << p_t;
          end
        end else if (m >= 0) p_clr = m;
        k = 1;
      end
    end
  end
  task automatic send(input logic on, input logic [3:0] n, input logic [2:0] o, input logic hold);
    for (int w = 0; !ev_ready && w < 40; w++) begin @(posedge clk); #1; end
    chk("ready_wait", ev_ready, 1);
    ev_valid = 1; ev_on = on; ev_note = n; ev_octave = o;
    @(posedge clk); #1;
    if (!hold) ev_valid = 0;
    repeat (NV) @(posedge clk);
    #1;
    got_ld = voice_ld; got_drop = drop; got_note = voice_note; got_oct = voice_octave;
    @(posedge clk); #1;
    ev_valid = 0;
  endtask
  task automatic pulse_reset();
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1;
    send(1, 0, 4, 0);
    chk("c4_ld", got_ld, 4'b0001);
    chk("c4_note", got_note, 0);
    chk("c4_oct", got_oct, 4);
    chk("c4_ready_t6", ev_ready, 1);
    chk("c4_active", voice_active, 4'b0001);
    send(1, 4, 4, 0);
    send(1, 7, 4, 0);
    chk("ceg_active", voice_active, 4'b0111);
    send(0, 4, 4, 0);
    chk("offe_ld", got_ld, 0);
    chk("offe_active", voice_active, 4'b0101);
    send(1, 9, 4, 0);
    chk("a4_reuse", got_ld, 4'b0010);
    send(1, 11, 3, 0);
    chk("full_active", voice_active, 4'b1111);
    send(1, 11, 5, 0);
`ifdef VOICE_ALLOC_STEAL_EN
    chk("b5_steal_ld", got_ld, 4'b0001);
    chk("b5_steal_drop", got_drop, 0);
`else
    chk("b5_reject_drop", got_drop, 1);
    chk("b5_reject_ld", got_ld, 0);
    chk("b5_reject_active", voice_active, 4'b1111);
`endif
    pulse_reset();
    send(1, 2, 3, 0);
    chk("d3a_ld", got_ld, 4'b0001);
    send(1, 2, 3, 0);
    chk("d3b_ld", got_ld, 4'b0001);
    chk("d3_active", voice_active, 4'b0001);
    send(1, 13, 4, 0);
    chk("bad_note_drop", got_drop, 1);
    chk("bad_note_active", voice_active, 4'b0001);
    send(0, 5, 2, 0);
    chk("absent_off", {got_ld, got_drop}, 0);
    send(1, 3, 3, 1);
    chk("hold_ld", got_ld, 4'b0010);
    pulse_reset();
    send(1, 0, 4, 0);
    repeat (15) send(1, 1, 4, 0);
    send(1, 2, 4, 0);
    send(1, 3, 4, 0);
    send(1, 5, 4, 0);
`ifdef VOICE_ALLOC_STEAL_EN
    chk("sat_oldest", got_ld, 4'b0001);
`endif
    for (int w = 0; !ev_ready && w < 40; w++) begin @(posedge clk); #1; end
    ev_valid = 1; ev_on = 1; ev_note = 6; ev_octave = 2;
    @(posedge clk); #1;
    ev_valid = 0;
    @(posedge clk); #1;
    reset = 0;
    #1;
    chk("abort_active", voice_active, 0);
    chk("abort_ready", ev_ready, 0);
    @(posedge clk); #1;
    reset = 1;
    repeat (NV + 3) @(posedge clk);
    #1;
    chk("abort_idle", ev_ready, 1);
    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      send($urandom_range(0, 99) < 65, r < 8 ? 4'(r % 4) : 4'(12 + r % 2), 3'($urandom_range(3, 4)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
